// File: rtl/cache_miss_ctrl_pkg.sv
// Shared types for the cache miss controller.
// Widths, way count, FSM state encoding and a multi-hit helper.
package cache_miss_ctrl_pkg;

    localparam int INDEX_WIDTH = 6;
    localparam int TAG_WIDTH   = 8;
    localparam int NUM_WAYS    = 4;

    typedef enum logic [2:0] {
        CMC_IDLE      = 3'd0,
        CMC_LOOKUP    = 3'd1,
        CMC_VICTIM    = 3'd2,
        CMC_FILL_REQ  = 3'd3,
        CMC_FILL_WAIT = 3'd4,
        CMC_UPDATE    = 3'd5,
        CMC_RESP      = 3'd6
    } cmc_state_e;

    // True when two or more ways matched the same tag.
    function automatic logic multi_hit(input logic [NUM_WAYS-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating incrementer.
// Ports: clk, reset_i (sync, high), inc_i, cnt_o (sticks at all-ones).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Single-outstanding miss controller for a 4-way cache.
// Ports: CPU req/resp, tag array, LRU update/query, mem refill, stats.
module cache_miss_ctrl
    import cache_miss_ctrl_pkg::*;
#(
    parameter int STAT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req_valid,
    output logic                   cpu_req_ready,
    input  logic [INDEX_WIDTH-1:0] cpu_req_idx,
    input  logic [TAG_WIDTH-1:0]   cpu_req_tag,
    output logic                   cpu_resp_valid,
    output logic [1:0]             cpu_resp_way,
    output logic                   cpu_resp_hit,
    output logic [INDEX_WIDTH-1:0] lookup_idx,
    output logic [TAG_WIDTH-1:0]   lookup_tag,
    input  logic [NUM_WAYS-1:0]    hit_vec,
    output logic                   tag_we,
    output logic [1:0]             tag_way,
    output logic                   lru_update_en,
    output logic [INDEX_WIDTH-1:0] lru_set_idx,
    output logic [1:0]             lru_accessed_way,
    output logic [INDEX_WIDTH-1:0] lru_query_idx,
    input  logic [1:0]             lru_victim_way,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [INDEX_WIDTH-1:0] mem_req_idx,
    output logic [TAG_WIDTH-1:0]   mem_req_tag,
    input  logic                   mem_resp_valid,
    output logic [STAT_W-1:0]      hit_cnt,
    output logic [STAT_W-1:0]      miss_cnt,
    output logic                   multi_hit_err
);

    cmc_state_e             state_q;
    logic [INDEX_WIDTH-1:0] r_idx_q;
    logic [TAG_WIDTH-1:0]   r_tag_q;
    logic [1:0]             r_way_q;
    logic                   hit_q;
    logic                   ready_q;
    logic                   mreq_q;
    logic                   upd_q;
    logic                   resp_q;
    logic                   mhe_q;

    logic       any_hit;
    logic [1:0] hit_way;

    assign any_hit = |hit_vec;

    // Lowest matching way wins on a multi-hit.
    always_comb begin
        hit_way = 2'd0;
        if (hit_vec[0]) begin
            hit_way = 2'd0;
        end else if (hit_vec[1]) begin
            hit_way = 2'd1;
        end else if (hit_vec[2]) begin
            hit_way = 2'd2;
        end else if (hit_vec[3]) begin
            hit_way = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CMC_IDLE;
            r_idx_q <= '0;
            r_tag_q <= '0;
            r_way_q <= '0;
            hit_q   <= 1'b0;
            ready_q <= 1'b1;
            mreq_q  <= 1'b0;
            upd_q   <= 1'b0;
            resp_q  <= 1'b0;
            mhe_q   <= 1'b0;
        end else begin
            upd_q  <= 1'b0;
            resp_q <= 1'b0;
            unique case (state_q)
                CMC_IDLE: begin
                    if (cpu_req_valid) begin
                        r_idx_q <= cpu_req_idx;
                        r_tag_q <= cpu_req_tag;
                        ready_q <= 1'b0;
                        state_q <= CMC_LOOKUP;
                    end
                end
                CMC_LOOKUP: begin
                    hit_q <= any_hit;
                    if (any_hit) begin
                        r_way_q <= hit_way;
                        upd_q   <= 1'b1;
                        state_q <= CMC_UPDATE;
                        if (multi_hit(hit_vec)) begin
                            mhe_q <= 1'b1;
                        end
                    end else begin
                        state_q <= CMC_VICTIM;
                    end
                end
                CMC_VICTIM: begin
                    // LRU output is registered on r_idx, valid only now.
                    r_way_q <= lru_victim_way;
                    mreq_q  <= 1'b1;
                    state_q <= CMC_FILL_REQ;
                end
                CMC_FILL_REQ: begin
                    if (mem_req_ready) begin
                        mreq_q  <= 1'b0;
                        state_q <= CMC_FILL_WAIT;
                    end
                end
                CMC_FILL_WAIT: begin
                    if (mem_resp_valid) begin
                        upd_q   <= 1'b1;
                        state_q <= CMC_UPDATE;
                    end
                end
                CMC_UPDATE: begin
                    resp_q  <= 1'b1;
                    state_q <= CMC_RESP;
                end
                CMC_RESP: begin
                    ready_q <= 1'b1;
                    state_q <= CMC_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= CMC_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(STAT_W)) u_hit_cnt (
        .clk     (clk),
        .reset_i (reset),
        .inc_i   ((state_q == CMC_LOOKUP) && any_hit),
        .cnt_o   (hit_cnt)
    );

    sat_counter #(.W(STAT_W)) u_miss_cnt (
        .clk     (clk),
        .reset_i (reset),
        .inc_i   ((state_q == CMC_LOOKUP) && !any_hit),
        .cnt_o   (miss_cnt)
    );

    assign cpu_req_ready    = ready_q;
    assign cpu_resp_valid   = resp_q;
    assign cpu_resp_way     = r_way_q;
    assign cpu_resp_hit     = hit_q;
    assign lookup_idx       = r_idx_q;
    assign lookup_tag       = r_tag_q;
    assign lru_query_idx    = r_idx_q;
    assign lru_set_idx      = r_idx_q;
    assign lru_accessed_way = r_way_q;
    assign lru_update_en    = upd_q;
    assign mem_req_idx      = r_idx_q;
    assign mem_req_tag      = r_tag_q;
    assign multi_hit_err    = mhe_q;
    assign tag_way          = r_way_q;

    // Reset kills the refill request and write in the same cycle.
    assign mem_req_valid = mreq_q && !reset;
    assign tag_we = (state_q == CMC_FILL_WAIT) && mem_resp_valid && !reset;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl with tag/LRU/memory models.
// Random traffic plus miss, backpressure, multi-hit and reset cases.
module tb_cache_miss_ctrl;
    import cache_miss_ctrl_pkg::*;

    localparam int SW = 2;
    localparam int IW = INDEX_WIDTH;
    localparam int TW = TAG_WIDTH;
    localparam int NS = 1 << IW;
    localparam int SATMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cpu_req_valid;
    logic          cpu_req_ready;
    logic [IW-1:0] cpu_req_idx;
    logic [TW-1:0] cpu_req_tag;
    logic          cpu_resp_valid;
    logic [1:0]    cpu_resp_way;
    logic          cpu_resp_hit;
    logic [IW-1:0] lookup_idx;
    logic [TW-1:0] lookup_tag;
    logic [3:0]    hit_vec;
    logic          tag_we;
    logic [1:0]    tag_way;
    logic          lru_update_en;
    logic [IW-1:0] lru_set_idx;
    logic [1:0]    lru_accessed_way;
    logic [IW-1:0] lru_query_idx;
    logic [1:0]    lru_victim_way;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [IW-1:0] mem_req_idx;
    logic [TW-1:0] mem_req_tag;
    logic          mem_resp_valid;
    logic [SW-1:0] hit_cnt;
    logic [SW-1:0] miss_cnt;
    logic          multi_hit_err;

    cache_miss_ctrl #(.STAT_W(SW)) dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_req_valid    (cpu_req_valid),
        .cpu_req_ready    (cpu_req_ready),
        .cpu_req_idx      (cpu_req_idx),
        .cpu_req_tag      (cpu_req_tag),
        .cpu_resp_valid   (cpu_resp_valid),
        .cpu_resp_way     (cpu_resp_way),
        .cpu_resp_hit     (cpu_resp_hit),
        .lookup_idx       (lookup_idx),
        .lookup_tag       (lookup_tag),
        .hit_vec          (hit_vec),
        .tag_we           (tag_we),
        .tag_way          (tag_way),
        .lru_update_en    (lru_update_en),
        .lru_set_idx      (lru_set_idx),
        .lru_accessed_way (lru_accessed_way),
        .lru_query_idx    (lru_query_idx),
        .lru_victim_way   (lru_victim_way),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_idx      (mem_req_idx),
        .mem_req_tag      (mem_req_tag),
        .mem_resp_valid   (mem_resp_valid),
        .hit_cnt          (hit_cnt),
        .miss_cnt         (miss_cnt),
        .multi_hit_err    (multi_hit_err)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // ---------------- environment: tag array and age-based LRU
    logic [TW-1:0] env_tag [NS][4];
    logic          env_val [NS][4];
    int            env_age [NS][4];
    logic          env_clr;
    logic          ovr_en;
    logic [3:0]    ovr_hv;
    logic [3:0]    hv_env;

    always_comb begin
        hv_env = 4'b0;
        for (int w = 0; w < 4; w++) begin
            if (env_val[lookup_idx][w] && env_tag[lookup_idx][w] == lookup_tag)
                hv_env[w] = 1'b1;
        end
        hit_vec = ovr_en ? ovr_hv : hv_env;
    end

    always @(posedge clk) begin
        if (env_clr) begin
            for (int s = 0; s < NS; s++) begin
                for (int w = 0; w < 4; w++) begin
                    env_val[s][w] <= 1'b0;
                    env_tag[s][w] <= '0;
                    env_age[s][w] <= w;
                end
            end
            lru_victim_way <= 2'd3;
        end else begin
            if (tag_we) begin
                env_tag[lookup_idx][tag_way] <= lookup_tag;
                env_val[lookup_idx][tag_way] <= 1'b1;
            end
            if (lru_update_en) begin
                for (int w = 0; w < 4; w++) begin
                    if (w == int'(lru_accessed_way))
                        env_age[lru_set_idx][w] <= 0;
                    else if (env_age[lru_set_idx][w] <
                             env_age[lru_set_idx][lru_accessed_way])
                        env_age[lru_set_idx][w] <= env_age[lru_set_idx][w] + 1;
                end
            end
            for (int w = 0; w < 4; w++) begin
                if (env_age[lru_query_idx][w] == 3)
                    lru_victim_way <= 2'(w);
            end
        end
    end

    // ---------------- memory responder
    int rdly = 0;
    int rspd = 1;
    int cur_idx = 0;
    int cur_tag = 0;
    int cur_way = 0;
    bit exp_tagwe = 1'b1;
    int n_fill = 0;

    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    end

    always begin
        int held;
        @(negedge clk);
        if (mem_req_valid) begin
            held = 1;
            for (int k = 0; k < rdly; k++) begin
                @(negedge clk);
                if (mem_req_valid) held++;
            end
            check("mem_req_hold", held, rdly + 1);
            check("mem_req_idx", mem_req_idx, cur_idx);
            check("mem_req_tag", mem_req_tag, cur_tag);
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            n_fill++;
            check("mem_req_drop", mem_req_valid, 0);
            for (int k = 1; k < rspd; k++) @(negedge clk);
            mem_resp_valid = 1'b1;
            #1;
            check("tag_we", tag_we, exp_tagwe);
            if (exp_tagwe) check("tag_way", tag_way, cur_way);
            @(negedge clk);
            mem_resp_valid = 1'b0;
        end
    end

    // ---------------- reference model: per-set tags and recency list
    typedef struct {
        int way;
        int hit;
        int idx;
        int hc;
        int mc;
        int rcyc;
    } exp_t;

    exp_t sbq[$];

    logic [TW-1:0] m_tag [NS][4];
    bit            m_val [NS][4];
    int            m_ord [NS][4];
    int m_hits = 0;
    int m_miss = 0;
    int m_fills = 0;

    function automatic int sat(input int x);
        return (x > SATMAX) ? SATMAX : x;
    endfunction

    task automatic touch(input int s, input int w);
        int p;
        p = 0;
        for (int i = 0; i < 4; i++) if (m_ord[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_ord[s][i] = m_ord[s][i-1];
        m_ord[s][0] = w;
    endtask

    // ---------------- response monitor
    int   upd_cyc = -10;
    int   upd_set = 0;
    int   upd_way = 0;
    exp_t me;

    always @(negedge clk) begin
        if (lru_update_en) begin
            upd_cyc = cyc;
            upd_set = int'(lru_set_idx);
            upd_way = int'(lru_accessed_way);
        end
        if (cpu_resp_valid) begin
            if (sbq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_resp: got response way %0d, expected none",
                         cpu_resp_way);
            end else begin
                me = sbq.pop_front();
                check("resp_way", cpu_resp_way, me.way);
                check("resp_hit", cpu_resp_hit, me.hit);
                check("resp_cycle", cyc, me.rcyc);
                check("hit_cnt", hit_cnt, sat(me.hc));
                check("miss_cnt", miss_cnt, sat(me.mc));
                check("lru_upd_cycle", upd_cyc, cyc - 1);
                check("lru_upd_set", upd_set, me.idx);
                check("lru_upd_way", upd_way, me.way);
            end
        end
    end

    // ---------------- stimulus
    // mode 0: normal, 1: forced hit_vec 1010, 2: aborted by reset
    task automatic issue(input int idx, input int tag, input int rd,
                         input int rs, input int mode);
        exp_t e;
        int   n;
        int   way;
        int   hit;
        n = 0;
        way = 0;
        hit = 0;
        cpu_req_valid = 1'b1;
        cpu_req_idx   = IW'(idx);
        cpu_req_tag   = TW'(tag);
        while (!cpu_req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_req_ready) begin
            nvec++;
            nerr++;
            $display("FAIL req_accept: ready stayed 0, expected 1");
            cpu_req_valid = 1'b0;
            return;
        end
        rdly = (rd < 0) ? int'($urandom_range(0, 4)) : rd;
        rspd = (rs < 0) ? int'($urandom_range(1, 3)) : rs;
        if (mode == 1) begin
            hit = 1;
            way = 1;
        end else begin
            for (int w = 3; w >= 0; w--) begin
                if (m_val[idx][w] && m_tag[idx][w] == TW'(tag)) begin
                    hit = 1;
                    way = w;
                end
            end
        end
        if (hit == 0) begin
            way = m_ord[idx][3];
            m_fills++;
            if (mode != 2) begin
                m_tag[idx][way] = TW'(tag);
                m_val[idx][way] = 1'b1;
            end
        end
        cur_idx   = idx;
        cur_tag   = tag;
        cur_way   = way;
        exp_tagwe = (mode != 2);
        if (mode != 2) begin
            touch(idx, way);
            if (hit != 0) m_hits++;
            else m_miss++;
            e.way  = way;
            e.hit  = hit;
            e.idx  = idx;
            e.hc   = m_hits;
            e.mc   = m_miss;
            e.rcyc = cyc + ((hit != 0) ? 3 : 5 + rdly + rspd);
            sbq.push_back(e);
        end
        @(negedge clk);
        cpu_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || !cpu_req_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            nvec++;
            nerr++;
            $display("FAIL drain: %0d responses pending, expected 0", sbq.size());
        end
    endtask

    task automatic check_reset_state();
        check("rst_ready", cpu_req_ready, 1);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_tag_we", tag_we, 0);
        check("rst_lru_update_en", lru_update_en, 0);
        check("rst_resp_valid", cpu_resp_valid, 0);
        check("rst_resp_way", cpu_resp_way, 0);
        check("rst_resp_hit", cpu_resp_hit, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        check("rst_multi_hit_err", multi_hit_err, 0);
        check("rst_lookup_idx", lookup_idx, 0);
    endtask

    initial begin
        reset = 1'b1;
        env_clr = 1'b1;
        ovr_en = 1'b0;
        ovr_hv = 4'b0;
        cpu_req_valid = 1'b0;
        cpu_req_idx = '0;
        cpu_req_tag = '0;
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_val[s][w] = 1'b0;
                m_tag[s][w] = '0;
                m_ord[s][w] = w;
            end
        end
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        env_clr = 1'b0;
        @(negedge clk);
        check("ready_after_reset", cpu_req_ready, 1);

        issue(3, 8'h21, 0, 2, 0);
        issue(3, 8'h21, -1, -1, 0);
        issue(5, 8'h12, 5, 1, 0);
        for (int i = 0; i < 60; i++)
            issue(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)), -1, -1, 0);
        drain();

        ovr_en = 1'b1;
        ovr_hv = 4'b1010;
        issue(5, 8'h33, -1, -1, 1);
        drain();
        ovr_en = 1'b0;
        check("multi_hit_err_set", multi_hit_err, 1);
        issue(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)), -1, -1, 0);
        drain();
        check("multi_hit_err_sticky", multi_hit_err, 1);

        issue(7, 8'hF0, 0, 4, 2);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_mem_req_valid", mem_req_valid, 0);
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        m_hits = 0;
        m_miss = 0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++)
            issue(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)), -1, -1, 0);
        drain();
        check("fill_count", n_fill, m_fills);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected end", cyc);
        $fatal(1, "watchdog");
    end

endmodule
